// File: rtl/ras_predictor.sv
// Return-address stack for the fetch stage: decodes calls/returns, predicts
// return targets combinationally and flags registered jalr mispredictions.
module ras_predictor #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_inst,
    input  logic             flush,
    output logic             pred_valid,
    output logic [31:0]      pred_addr,
    input  logic             chk_en,
    input  logic             chk_pred_valid,
    input  logic [31:0]      chk_pred,
    input  logic [31:0]      chk_actual,
    output logic             mispredict,
    output logic [PTR_W:0]   count
);

    localparam logic [6:0]       OP_JAL   = 7'b1101111;
    localparam logic [6:0]       OP_JALR  = 7'b1100111;
    localparam logic [PTR_W-1:0] TP_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    // Count saturates at DEPTH: overflow overwrites the oldest entry instead.
    function automatic logic [PTR_W:0] sat_inc(input logic [PTR_W:0] c);
        return (c == CNT_FULL) ? c : c + CNT_ONE;
    endfunction

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] tp_p1;
    logic [PTR_W:0]   cnt_p1;
    logic             mispredict_p1;

    logic [6:0]       opcode_p0;
    logic [4:0]       rd_p0;
    logic [4:0]       rs1_p0;
    logic [2:0]       funct3_p0;
    logic             is_jal_p0;
    logic             is_jalr_p0;
    logic             push_p0;
    logic             pop_p0;
    logic             pop_ok_p0;
    logic [31:0]      push_val_p0;
    logic [31:0]      top_entry_p0;
    logic [PTR_W-1:0] tp_nxt;
    logic [PTR_W:0]   cnt_nxt;
    logic             wr_en;
    logic             mis_nxt;
    logic             unused_bits;

    // Stage p0: fetch-side decode and same-cycle prediction
    assign opcode_p0  = if_inst[6:0];
    assign rd_p0      = if_inst[11:7];
    assign funct3_p0  = if_inst[14:12];
    assign rs1_p0     = if_inst[19:15];
    assign is_jal_p0  = (opcode_p0 == OP_JAL);
    assign is_jalr_p0 = (opcode_p0 == OP_JALR) && (funct3_p0 == 3'b000);

    // A jalr with both link registers equal is a plain call; differing ones pop then push.
    assign push_p0 = if_valid && (is_jal_p0 || is_jalr_p0) && is_link(rd_p0);
    assign pop_p0  = if_valid && is_jalr_p0 && is_link(rs1_p0)
                     && !(is_link(rd_p0) && (rd_p0 == rs1_p0));

    assign pop_ok_p0    = pop_p0 && (cnt_p1 != '0);
    assign push_val_p0  = if_pc + 32'd4;
    assign top_entry_p0 = mem[tp_p1];

    assign pred_valid = pop_ok_p0;
    assign pred_addr  = pop_ok_p0 ? {top_entry_p0[31:1], 1'b0} : 32'd0;

    assign unused_bits = ^{if_inst[31:20], top_entry_p0[0]};

    always_comb begin
        tp_nxt  = tp_p1;
        cnt_nxt = cnt_p1;
        wr_en   = 1'b0;
        if (pop_ok_p0) begin
            tp_nxt  = tp_p1 - TP_ONE;
            cnt_nxt = cnt_p1 - CNT_ONE;
        end
        if (push_p0) begin
            tp_nxt  = tp_nxt + TP_ONE;
            cnt_nxt = sat_inc(cnt_nxt);
            wr_en   = 1'b1;
        end
    end

    assign mis_nxt = chk_en && chk_pred_valid && (chk_pred != chk_actual);

    // Stage p1: registered stack pointer, occupancy and mispredict flag
    always_ff @(posedge clk) begin
        if (rst) begin
            tp_p1         <= '0;
            cnt_p1        <= '0;
            mispredict_p1 <= 1'b0;
        end else begin
            mispredict_p1 <= mis_nxt;
            if (flush) begin
                tp_p1  <= '0;
                cnt_p1 <= '0;
            end else begin
                tp_p1  <= tp_nxt;
                cnt_p1 <= cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst && !flush) begin
            mem[tp_nxt] <= push_val_p0;
        end
    end

    assign mispredict = mispredict_p1;
    assign count      = cnt_p1;

endmodule

// File: tb/tb_ras_predictor.sv
// Scoreboard bench for ras_predictor: directed scenarios followed by random
// traffic, checked against a queue-based return-address stack model.
module tb_ras_predictor;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             if_valid = 1'b0;
    logic [31:0]      if_pc = '0;
    logic [31:0]      if_inst = '0;
    logic             flush = 1'b0;
    logic             pred_valid;
    logic [31:0]      pred_addr;
    logic             chk_en = 1'b0;
    logic             chk_pred_valid = 1'b0;
    logic [31:0]      chk_pred = '0;
    logic [31:0]      chk_actual = '0;
    logic             mispredict;
    logic [PTR_W:0]   count;

    ras_predictor #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .flush          (flush),
        .pred_valid     (pred_valid),
        .pred_addr      (pred_addr),
        .chk_en         (chk_en),
        .chk_pred_valid (chk_pred_valid),
        .chk_pred       (chk_pred),
        .chk_actual     (chk_actual),
        .mispredict     (mispredict),
        .count          (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [31:0] pa;
        int          cnt;
        logic        mis;
        int          step;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] stk[$];
    logic        mis_m = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          nstep = 0;

    function automatic bit lnk(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic logic [31:0] mk_jal(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] mk_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [2:0] f3, input logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'b1100111};
    endfunction

    task automatic check(input string nm, input int step, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s step=%0d got=0x%08h expected=0x%08h", nm, step, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per cycle, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("pred_valid", e.step, {31'd0, pred_valid}, {31'd0, e.pv});
            check("pred_addr",  e.step, pred_addr, e.pa);
            check("count",      e.step, {28'd0, count}, e.cnt);
            check("mispredict", e.step, {31'd0, mispredict}, {31'd0, e.mis});
        end
    end

    // Predict this cycle's outputs, advance the model across the coming edge.
    task automatic cycle();
        exp_t        e;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [2:0]  f3;
        logic [31:0] top;
        bit          is_call_op;
        bit          is_jalr;
        bit          do_push;
        bit          do_pop;
        op  = if_inst[6:0];
        rd  = if_inst[11:7];
        f3  = if_inst[14:12];
        rs1 = if_inst[19:15];
        is_call_op = (op == 7'b1101111);
        is_jalr    = (op == 7'b1100111) && (f3 == 3'b000);
        do_push = if_valid && (is_call_op || is_jalr) && lnk(rd);
        do_pop  = if_valid && is_jalr && lnk(rs1) && !(lnk(rd) && rd == rs1);
        e.pv  = do_pop && (stk.size() > 0);
        top   = e.pv ? stk[$] : 32'd0;
        e.pa  = {top[31:1], 1'b0};
        e.cnt = stk.size();
        e.mis = mis_m;
        e.step = nstep;
        sbq.push_back(e);
        nstep++;
        if (rst) begin
            stk.delete();
            mis_m = 1'b0;
        end else begin
            mis_m = chk_en && chk_pred_valid && (chk_pred != chk_actual);
            if (flush) begin
                stk.delete();
            end else begin
                if (do_pop && stk.size() > 0) void'(stk.pop_back());
                if (do_push) begin
                    stk.push_back(if_pc + 32'd4);
                    if (stk.size() > DEPTH) void'(stk.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
        if_valid = 1'b1;
        if_pc    = pc;
        if_inst  = inst;
        cycle();
        if_valid = 1'b0;
    endtask

    task automatic idle();
        if_valid = 1'b0;
        cycle();
    endtask

    function automatic logic [4:0] pick_reg();
        int k;
        k = $urandom_range(0, 5);
        case (k)
            0: return 5'd0;
            1, 2: return 5'd1;
            3: return 5'd5;
            4: return 5'd6;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        idle();

        // Call then return
        fetch(32'h100, 32'h008000EF);
        fetch(32'h200, 32'h00008067);
        idle();

        // Nesting past capacity, then drain one beyond empty
        for (int k = 0; k < 9; k++) fetch(32'h1000 + 32'(16 * k), 32'h008000EF);
        for (int k = 0; k < 9; k++) fetch(32'h2000, 32'h00008067);
        idle();

        // Non-link jalr and underflow
        fetch(32'h400, 32'h008000EF);
        fetch(32'h404, mk_jalr(5'd0, 5'd6, 3'b000, 12'h0));
        fetch(32'h408, 32'h00008067);
        fetch(32'h40C, 32'h00008067);
        idle();

        // Coroutine swap then pop the replaced top
        fetch(32'h1FC, 32'h008000EF);
        fetch(32'h300, mk_jalr(5'd5, 5'd1, 3'b000, 12'h0));
        fetch(32'h500, 32'h00008067);
        idle();

        // Flush beats a simultaneous call
        for (int k = 0; k < 3; k++) fetch(32'h600 + 32'(4 * k), 32'h008000EF);
        flush = 1'b1;
        fetch(32'h700, 32'h008000EF);
        flush = 1'b0;
        fetch(32'h704, 32'h00008067);
        idle();

        // Mispredict pulse, then a correct prediction
        chk_en = 1'b1; chk_pred_valid = 1'b1; chk_pred = 32'h104; chk_actual = 32'h108;
        idle();
        chk_actual = 32'h104;
        idle();
        chk_en = 1'b0;
        idle();

        // Reset in the middle of a populated stack with a pending mispredict
        fetch(32'h800, 32'h008000EF);
        fetch(32'h810, 32'h008000EF);
        chk_en = 1'b1; chk_actual = 32'h999;
        idle();
        rst = 1'b1;
        fetch(32'h820, 32'h008000EF);
        rst = 1'b0;
        chk_en = 1'b0;
        idle();
        fetch(32'h830, 32'h00008067);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if_valid = ($urandom_range(0, 99) < 85);
            if_pc    = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            case ($urandom_range(0, 3))
                0: if_inst = mk_jal(pick_reg(), 20'($urandom()));
                1, 2: if_inst = mk_jalr(pick_reg(), pick_reg(),
                                        ($urandom_range(0, 7) == 0) ? 3'($urandom()) : 3'b000,
                                        12'($urandom()));
                default: if_inst = $urandom();
            endcase
            flush          = ($urandom_range(0, 99) < 5);
            rst            = ($urandom_range(0, 99) < 1);
            chk_en         = $urandom_range(0, 1);
            chk_pred_valid = $urandom_range(0, 1);
            r              = $urandom();
            chk_pred       = r & 32'hFFFF_FFFE;
            chk_actual     = $urandom_range(0, 1) ? chk_pred : ($urandom() & 32'hFFFF_FFFE);
            cycle();
        end
        rst = 1'b0; flush = 1'b0; chk_en = 1'b0; if_valid = 1'b0;
        idle();
        idle();

        @(negedge clk);
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d expected=0 pending entries", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ras_predictor.md
Name: ras_predictor

Overview:
- Return-address stack for the fetch stage of the pipeline.
- Calls (jal/jalr that write a link register) push pc+4.
- Returns (jalr that reads a link register) pop the stack and supply a predicted target the same cycle, before the execute-stage jalr target adder resolves the real address.
- A compare port checks each prediction against the resolved jalr target and raises a registered mispredict flag; flush empties the stack.

Parameters:
- DEPTH, 8, number of stack entries; must be a power of two and at least 2.
- PTR_W, 3, log2(DEPTH); width of the top pointer.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- if_valid  input  1  fetch-stage instruction is valid and advancing this cycle.
- if_pc  input  32  PC of the fetch-stage instruction.
- if_inst  input  32  fetch-stage instruction word.
- flush  input  1  pipeline redirect; empties the stack.
- pred_valid  output  1  combinational; a return was detected and the stack is non-empty.
- pred_addr  output  32  combinational; predicted return target, bit 0 forced to 0.
- chk_en  input  1  execute stage resolves a jalr this cycle.
- chk_pred_valid  input  1  that jalr was predicted by this block.
- chk_pred  input  32  target predicted at fetch, carried down the pipe.
- chk_actual  input  32  resolved jalr target (bit 0 already cleared).
- mispredict  output  1  registered; one-cycle pulse on a wrong prediction.
- count  output  PTR_W+1  registered; number of valid entries, 0..DEPTH.

Behaviour:
- Decode applies only when if_valid=1. link(r) means r==1 or r==5.
  - jal: opcode 1101111. Push when link(rd).
  - jalr: opcode 1100111 and funct3 000.
    - link(rd) and not link(rs1): push.
    - link(rs1) and not link(rd): pop.
    - link(rd) and link(rs1) and rd==rs1: push only.
    - link(rd) and link(rs1) and rd!=rs1: pop then push (coroutine). The prediction comes from the old top; afterwards the top entry is replaced by pc+4, top pointer and count unchanged.
  - All other cases: no stack action.
- Push value is if_pc+4, computed modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
- Storage is a circular buffer: DEPTH x 32 entries, top pointer tp (PTR_W bits), count.
  - Push: tp <= tp+1 (wraps), mem[tp+1] <= value, count <= min(count+1, DEPTH).
  - Overflow at count==DEPTH: silently overwrites the oldest entry; count stays at DEPTH.
  - Pop with count>0: tp <= tp-1 (wraps), count <= count-1.
  - Pop with count==0 (underflow): pred_valid=0, tp and count unchanged, pred_addr=0.
- Prediction is combinational in the same cycle as the pop: pred_valid = pop_detected & (count!=0); pred_addr = {mem[tp][31:1],1'b0} when pred_valid=1, else 0.
- When if_valid=0, no push or pop occurs and pred_valid=0.
- flush=1 on an edge: count <= 0 and tp <= 0. Any push or pop decoded that cycle is discarded (flush wins). pred_valid is still driven combinationally that cycle.
- mispredict is registered on each edge as chk_en & chk_pred_valid & (chk_pred != chk_actual).
  - Unpredicted jalrs (chk_pred_valid=0) never flag.
  - flush does not clear mispredict; the check stage is independent of fetch state.
- Reset (rst=1 on an edge, including mid-operation): tp=0, count=0, mispredict=0. Memory contents are don't-care; they are unreadable while count==0. Reset has priority over flush and over all decode actions.
- Latency: prediction is 0 cycles; stack update is visible the cycle after the edge; mispredict is 1 cycle after chk_en.

Test Plan:
- Call/return: jal x1 at pc 0x100 (if_inst 0x008000EF), then jalr x0,0(x1) (0x00008067) -> on the return cycle pred_valid=1, pred_addr=0x104; count goes 1 then 0.
- Nesting and overflow: 9 pushes with pc=0x1000+16k (k=0..8), then 9 pops -> pops 1..8 predict 0x1084 down to 0x1014 with pred_valid=1; 9th pop pred_valid=0, pred_addr=0; count stays 0.
- Underflow and non-link: jalr x0,0(x6) -> no pop, count unchanged; pop on an empty stack -> pred_valid=0, count stays 0.
- Coroutine: stack top 0x200, jalr x5,0(x1) at pc 0x300 -> pred_addr=0x200; next cycle top=0x304, count unchanged.
- Flush priority: count=3, flush=1 with a simultaneous jal x1 -> next cycle count=0; a following pop gives pred_valid=0.
- Check and reset: chk_en=1, chk_pred_valid=1, chk_pred=0x104, chk_actual=0x108 -> mispredict=1 for exactly one cycle; equal values -> 0; rst mid-stack -> count=0 and mispredict=0 on the next cycle.
